// File: rtl/sipo_shift_register.sv
// Serial-in, parallel-out shift register with a bit counter, a registered
// completed-word output and a one-cycle word-valid strobe for deserializing.
module sipo_shift_register #(
  parameter int               WIDTH        = 4,
  parameter int               SHIFT_MSB_IN = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         d,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic [WIDTH-1:0]             word,
  output logic                         word_valid
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;

  logic [WIDTH-1:0] w_shifted;
  logic             w_word_done;

  // Direction is fixed at elaboration; both forms are a plain one-bit shift.
  always_comb begin
    w_shifted = r_q;
    if (SHIFT_MSB_IN != 0) begin
      w_shifted = {d, r_q[WIDTH-1:1]};
    end else begin
      w_shifted = {r_q[WIDTH-2:0], d};
    end
  end

  assign w_word_done = (r_count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q          <= RESET_VALUE;
      r_count      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_q <= w_shifted;
      if (w_word_done) begin
        r_count      <= '0;
        r_word       <= w_shifted;
        r_word_valid <= 1'b1;
      end else begin
        r_count      <= r_count + CW'(1);
        r_word_valid <= 1'b0;
      end
    end
  end

  assign q          = r_q;
  assign bit_count  = r_count;
  assign word       = r_word;
  assign word_valid = r_word_valid;

endmodule

// File: tb/tb_sipo_shift_register.sv
// Directed bench for sipo_shift_register: MSB-in and LSB-in 4-bit, 8-bit
// MSB-in, and a non-zero reset value, all sharing one clock and stimulus.
module tb_sipo_shift_register;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;

  logic [3:0] q_m, word_m, q_l, word_l, q_r, word_r;
  logic [2:0] cnt_m, cnt_l, cnt_r;
  logic       wv_m, wv_l, wv_r;
  logic [7:0] q_8, word_8;
  logic [3:0] cnt_8;
  logic       wv_8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_shift_register #(.WIDTH(4), .SHIFT_MSB_IN(1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .q(q_m), .bit_count(cnt_m),
    .word(word_m), .word_valid(wv_m));

  sipo_shift_register #(.WIDTH(4), .SHIFT_MSB_IN(0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .q(q_l), .bit_count(cnt_l),
    .word(word_l), .word_valid(wv_l));

  sipo_shift_register #(.WIDTH(8), .SHIFT_MSB_IN(1)) u_w8 (
    .clk(clk), .rst(rst), .d(d), .q(q_8), .bit_count(cnt_8),
    .word(word_8), .word_valid(wv_8));

  sipo_shift_register #(.WIDTH(4), .SHIFT_MSB_IN(1), .RESET_VALUE(4'b1010)) u_rv (
    .clk(clk), .rst(rst), .d(d), .q(q_r), .bit_count(cnt_r),
    .word(word_r), .word_valid(wv_r));

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive_edge(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    d   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 1'b1);
    n_cmp++;
    if (q_m !== 4'b0000 || cnt_m !== 3'd0 || word_m !== 4'b0000 || wv_m !== 1'b0) begin
      n_err++;
      $display("FAIL reset_msb: q=%b cnt=%0d word=%b wv=%b, want q=0000 cnt=0 word=0000 wv=0",
               q_m, cnt_m, word_m, wv_m);
    end
    n_cmp++;
    if (q_r !== 4'b1010 || cnt_r !== 3'd0 || word_r !== 4'b0000 || wv_r !== 1'b0) begin
      n_err++;
      $display("FAIL reset_value: q=%b cnt=%0d word=%b wv=%b, want q=1010 cnt=0 word=0000 wv=0",
               q_r, cnt_r, word_r, wv_r);
    end
  endtask

  task automatic test_basic_shift();
    logic       bits [4];
    logic [3:0] exp_q [4];
    bits  = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_q = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    drive_edge(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, bits[i]);
      n_cmp++;
      if (q_m !== exp_q[i] || wv_m !== (i == 3)) begin
        n_err++;
        $display("FAIL basic_shift edge %0d: q=%b wv=%b, want q=%b wv=%b",
                 i + 1, q_m, wv_m, exp_q[i], (i == 3));
      end
    end
    n_cmp++;
    if (word_m !== 4'b1101) begin
      n_err++;
      $display("FAIL basic_word: word=%b, want 1101", word_m);
    end
    drive_edge(1'b0, 1'b0);
    n_cmp++;
    if (wv_m !== 1'b0 || word_m !== 4'b1101) begin
      n_err++;
      $display("FAIL basic_after: wv=%b word=%b, want wv=0 word=1101", wv_m, word_m);
    end
  endtask

  task automatic test_back_to_back();
    logic       bits  [8];
    logic [2:0] exp_c [8];
    logic [3:0] exp_w [8];
    bits  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_c = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_w = '{4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1001};
    drive_edge(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_edge(1'b0, bits[i]);
      n_cmp++;
      if (cnt_m !== exp_c[i] || word_m !== exp_w[i] || wv_m !== (i == 3 || i == 7)) begin
        n_err++;
        $display("FAIL stream edge %0d: cnt=%0d word=%b wv=%b, want cnt=%0d word=%b wv=%b",
                 i + 1, cnt_m, word_m, wv_m, exp_c[i], exp_w[i], (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic       bits  [4];
    logic [3:0] exp_q [4];
    bits  = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_q = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
    drive_edge(1'b1, 1'b0);
    drive_edge(1'b0, 1'b1);
    drive_edge(1'b0, 1'b1);
    drive_edge(1'b1, 1'b1);
    n_cmp++;
    if (q_m !== 4'b0000 || cnt_m !== 3'd0 || wv_m !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: q=%b cnt=%0d wv=%b, want q=0000 cnt=0 wv=0", q_m, cnt_m, wv_m);
    end
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, bits[i]);
      n_cmp++;
      if (q_m !== exp_q[i] || wv_m !== (i == 3)) begin
        n_err++;
        $display("FAIL mid_reset edge %0d: q=%b wv=%b, want q=%b wv=%b",
                 i + 1, q_m, wv_m, exp_q[i], (i == 3));
      end
    end
    n_cmp++;
    if (word_m !== 4'b1000) begin
      n_err++;
      $display("FAIL mid_reset_word: word=%b, want 1000", word_m);
    end
  endtask

  task automatic test_lsb_in();
    logic       bits  [4];
    logic [3:0] exp_q [4];
    bits  = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_q = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    drive_edge(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, bits[i]);
      n_cmp++;
      if (q_l !== exp_q[i] || wv_l !== (i == 3)) begin
        n_err++;
        $display("FAIL lsb_in edge %0d: q=%b wv=%b, want q=%b wv=%b",
                 i + 1, q_l, wv_l, exp_q[i], (i == 3));
      end
    end
    n_cmp++;
    if (word_l !== 4'b1011) begin
      n_err++;
      $display("FAIL lsb_word: word=%b, want 1011", word_l);
    end
  endtask

  task automatic test_width8();
    logic bits [8];
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    drive_edge(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_edge(1'b0, bits[i]);
      n_cmp++;
      if (wv_8 !== (i == 7) || cnt_8 !== 4'((i + 1) % 8)) begin
        n_err++;
        $display("FAIL width8 edge %0d: cnt=%0d wv=%b, want cnt=%0d wv=%b",
                 i + 1, cnt_8, wv_8, (i + 1) % 8, (i == 7));
      end
    end
    n_cmp++;
    if (q_8 !== 8'b11011101 || word_8 !== 8'b11011101) begin
      n_err++;
      $display("FAIL width8_word: q=%b word=%b, want 11011101 for both", q_8, word_8);
    end
  endtask

  initial begin
    test_reset();
    test_basic_shift();
    test_back_to_back();
    test_mid_reset();
    test_lsb_in();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
